// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int unsigned DEF_MUL_LAT = 5;
    localparam int unsigned DEF_DIV_LAT = 10;

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing {hi,lo}; keep flags a result that must not commit.
// Divide-by-zero behaviour selected by MDU_DIV0_KEEP_EN.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        keep
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               b_zero;
    logic               s_ovf;

    assign b_zero = (b == '0);
    assign s_ovf  = (a == 32'h8000_0000) && (b == '1);

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        quo_s  = '0;
        rem_s  = '0;
        quo_u  = '0;
        rem_u  = '0;
        // Operators are only evaluated on safe operands; zero and overflow handled below.
        if (!b_zero && !s_ovf) begin
            quo_s = $signed(a) / $signed(b);
            rem_s = $signed(a) % $signed(b);
        end
        if (!b_zero) begin
            quo_u = a / b;
            rem_u = a % b;
        end
    end

    always_comb begin
        hi   = '0;
        lo   = '0;
        keep = 1'b0;
        case (op)
            MDU_MULT:  {hi, lo} = prod_s;
            MDU_MULTU: {hi, lo} = prod_u;
            MDU_DIV: begin
                if (s_ovf) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else begin
                    lo = quo_s;
                    hi = rem_s;
                end
            end
            MDU_DIVU: begin
                lo = quo_u;
                hi = rem_u;
            end
            default: ;
        endcase
        if (is_div(op) && b_zero) begin
`ifdef MDU_DIV0_KEEP_EN
            keep = 1'b1;
`else
            lo = '1;
            hi = a;
`endif
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU sequencer: FSM, latency counter, pending result and HI/LO registers.
// Optional feature macro: MDU_DIV0_KEEP_EN (handled inside mdu_arith).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] S1,
    input  logic [31:0] S2,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    mdu_state_e    state;
    logic [CW-1:0] count;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_keep;

    mdu_op_e       op;
    logic          accept;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_keep;

    assign op     = mdu_op_e'(MDUOp);
    assign accept = Start && !Req && !Busy;

    mdu_arith u_arith (
        .op   (op),
        .a    (S1),
        .b    (S2),
        .hi   (res_hi),
        .lo   (res_lo),
        .keep (res_keep)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            Busy      <= 1'b0;
            count     <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_keep <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                // Result is computed from this edge's operands and held until commit.
                                state     <= ST_BUSY;
                                Busy      <= 1'b1;
                                count     <= is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                                pend_hi   <= res_hi;
                                pend_lo   <= res_lo;
                                pend_keep <= res_keep;
                            end
                            MDU_MTHI: HI <= S1;
                            MDU_MTLO: LO <= S1;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (count == CW'(1)) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        count <= '0;
                        if (!pend_keep) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
